// File: rtl/alu_share_arbiter_pkg.sv
// Types shared by the ALU sharing arbiter: operation bundle, result record and sizing constants.
package alu_share_arbiter_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned TRANS_ID_BITS     = 3;
  localparam int unsigned ALU_SHARE_MAX_REQ = 2;
  localparam int unsigned OWNER_BITS        = (ALU_SHARE_MAX_REQ > 1) ? $clog2(ALU_SHARE_MAX_REQ) : 1;

  typedef logic [XLEN-1:0] xlen_t;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    XORL = 4'd2,
    ANDL = 4'd3,
    EQ   = 4'd4,
    NE   = 4'd5
  } fu_op_t;

  typedef struct packed {
    fu_op_t                   operation;
    xlen_t                    operand_a;
    xlen_t                    operand_b;
    xlen_t                    imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    xlen_t                    result;
    logic                     branch_res;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [OWNER_BITS-1:0]    owner;
  } alu_share_res_t;

endpackage

// File: rtl/alu_share_arbiter_fifo.sv
// Two-entry in-order result buffer (head/tail registers, no fall-through).
module alu_share_arbiter_fifo
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  input  logic           push_i,
  input  alu_share_res_t data_i,
  input  logic           pop_i,
  output alu_share_res_t data_o,
  output logic           full_o,
  output logic           empty_o
);

  alu_share_res_t head_q, head_d, tail_q, tail_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           push_ok, pop_ok;

  assign full_o  = (cnt_q == 2'(DEPTH));
  assign empty_o = (cnt_q == 2'd0);
  assign data_o  = head_q;

  // Entries are never cleared on pop or flush so the head keeps its last value when empty.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    push_ok = push_i & ~full_o;
    pop_ok  = pop_i & ~empty_o;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = data_i;
        else               tail_d = data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: head_d = data_i;
      default: ;
    endcase
    if (flush_i) cnt_d = 2'd0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= 2'd2);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between NR_REQ issue requesters,
// with results registered into a 2-entry buffer under valid/ready backpressure.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ    = 2,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [NR_REQ-1:0]     req_valid_i,
  output logic [NR_REQ-1:0]     req_ready_o,
  input  fu_data_t [NR_REQ-1:0] req_data_i,
  output fu_data_t              alu_data_o,
  input  xlen_t                 alu_result_i,
  input  logic                  alu_branch_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output alu_share_res_t        res_o
);

  localparam int unsigned PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic [PTR_W-1:0] rr_q, rr_d, grant, cand;
  logic             found, any_valid, space, handshake, buf_full, buf_empty, pop;
  alu_share_res_t   push_data;

  assign any_valid = |req_valid_i;
  // Space comes from the registered count, so res_ready_i never reaches req_ready_o.
  assign space     = ~buf_full;
  assign handshake = |(req_valid_i & req_ready_o);
  assign pop       = res_valid_o & res_ready_i;

  always_comb begin
    grant = rr_q;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      cand = PTR_W'((32'(rr_q) + i) % NR_REQ);
      if (!found && req_valid_i[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (any_valid && space && !flush_i) req_ready_o[grant] = 1'b1;
  end

  always_comb begin
    alu_data_o           = '0;
    alu_data_o.operation = ADD;
    if (any_valid) alu_data_o = req_data_i[grant];
  end

  always_comb begin
    rr_d = rr_q;
    if (handshake) rr_d = (32'(grant) == NR_REQ - 1) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

  always_comb begin
    push_data            = '0;
    push_data.result     = alu_result_i;
    push_data.branch_res = alu_branch_i;
    push_data.trans_id   = req_data_i[grant].trans_id;
    push_data.owner      = OWNER_BITS'(grant);
  end

  alu_share_arbiter_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (handshake),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (res_o),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  assign res_valid_o = ~buf_empty;

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_o));
  a_res_stable:    assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    res_valid_o && !res_ready_i |=> $stable(res_o));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_ni, flush_i, res_ready_i, alu_branch_i, res_valid_o;
  logic [1:0]     req_valid_i, req_ready_o;
  fu_data_t [1:0] req_data_i;
  fu_data_t       alu_data_o;
  xlen_t          alu_result_i;
  alu_share_res_t res_o, alu_tmp;

  int total = 0;
  int bad   = 0;

  int             rr_m;
  alu_share_res_t q_m[$];

  always #5 clk_i = ~clk_i;

  alu_share_arbiter #(.NR_REQ(2), .BUF_DEPTH(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data_i   (req_data_i),
    .alu_data_o   (alu_data_o),
    .alu_result_i (alu_result_i),
    .alu_branch_i (alu_branch_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_o        (res_o)
  );

  function automatic alu_share_res_t mk_res(fu_data_t d, int k);
    alu_share_res_t r;
    r = '0;
    case (d.operation)
      ADD:  r.result = d.operand_a + d.operand_b;
      SUB:  r.result = d.operand_a - d.operand_b;
      XORL: r.result = d.operand_a ^ d.operand_b;
      ANDL: r.result = d.operand_a & d.operand_b;
      EQ:   r.branch_res = (d.operand_a == d.operand_b);
      NE:   r.branch_res = (d.operand_a != d.operand_b);
      default: ;
    endcase
    r.trans_id = d.trans_id;
    r.owner    = OWNER_BITS'(k);
    return r;
  endfunction

  // External ALU stand-in.
  always_comb begin
    alu_tmp      = mk_res(alu_data_o, 0);
    alu_result_i = alu_tmp.result;
    alu_branch_i = alu_tmp.branch_res;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_op(input int k, input fu_op_t op, input xlen_t a, input xlen_t b,
                        input logic [TRANS_ID_BITS-1:0] tid);
    req_data_i[k] = '{operation: op, operand_a: a, operand_b: b, imm: '0, trans_id: tid};
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    req_valid_i = 2'b00;
    flush_i     = 1'b0;
    res_ready_i = 1'b1;
    req_data_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    rr_m   = 0;
    q_m.delete();
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    req_valid_i = 2'b00;
    flush_i     = 1'b0;
    res_ready_i = 1'b1;
    req_data_i  = '0;
    #2;
    total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready_o); end
    total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", res_valid_o); end
    total++; if (res_o !== '0) begin bad++; $display("FAIL reset_res got=%h exp=0", res_o); end
    total++; if (alu_data_o !== '0) begin bad++; $display("FAIL reset_alu got=%h exp=0", alu_data_o); end
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_valid_i = 2'b01;
    set_op(0, ADD, 32'd5, 32'd7, 3'd3);
    @(negedge clk_i);
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", req_ready_o); end
    total++; if (alu_data_o.operand_a !== 32'd5 || alu_data_o.operand_b !== 32'd7)
      begin bad++; $display("FAIL single_alu got=%0d,%0d exp=5,7", alu_data_o.operand_a, alu_data_o.operand_b); end
    tick();
    req_valid_i = 2'b00;
    @(negedge clk_i);
    total++; if (res_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", res_valid_o); end
    total++; if (res_o.result !== 32'd12 || res_o.owner !== 1'b0 || res_o.trans_id !== 3'd3)
      begin bad++; $display("FAIL single_res got=%0d/%0d/%0d exp=12/0/3", res_o.result, res_o.owner, res_o.trans_id); end
    total++; if (alu_data_o !== '0) begin bad++; $display("FAIL idle_alu got=%h exp=0", alu_data_o); end
    tick();
    @(negedge clk_i);
    total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", res_valid_o); end
  endtask

  task automatic test_back_to_back();
    alu_share_res_t prev;
    prev = '0;
    do_reset();
    req_valid_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) set_op(k, ADD, 32'(i * 10 + k), 32'd1, 3'(2 * i + k));
      @(negedge clk_i);
      total++; if (req_ready_o !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        begin bad++; $display("FAIL b2b_ready[%0d] got=%b", i, req_ready_o); end
      if (i > 0) begin
        total++; if (res_valid_o !== 1'b1 || res_o !== prev)
          begin bad++; $display("FAIL b2b_res[%0d] got=%b/%h exp=1/%h", i, res_valid_o, res_o, prev); end
      end
      prev = '0;
      prev.result = 32'(i * 10 + (i % 2) + 1);
      prev.trans_id = 3'(2 * i + (i % 2));
      prev.owner = OWNER_BITS'(i % 2);
      tick();
    end
    req_valid_i = 2'b00;
    @(negedge clk_i);
    total++; if (res_valid_o !== 1'b1 || res_o !== prev)
      begin bad++; $display("FAIL b2b_last got=%b/%h exp=1/%h", res_valid_o, res_o, prev); end
    tick();
    @(negedge clk_i);
    total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", res_valid_o); end
  endtask

  task automatic test_backpressure();
    alu_share_res_t ea, eb, ec;
    ea = '{result: 32'd101, branch_res: 1'b0, trans_id: 3'd1, owner: 1'b0};
    eb = '{result: 32'd42,  branch_res: 1'b0, trans_id: 3'd2, owner: 1'b1};
    ec = '{result: 32'd202, branch_res: 1'b0, trans_id: 3'd5, owner: 1'b0};
    do_reset();
    res_ready_i = 1'b0;
    req_valid_i = 2'b11;
    set_op(0, ADD, 32'd100, 32'd1, 3'd1);
    set_op(1, SUB, 32'd50, 32'd8, 3'd2);
    @(negedge clk_i);
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL bp_ready0 got=%b exp=01", req_ready_o); end
    tick();
    set_op(0, ADD, 32'd200, 32'd2, 3'd5);
    @(negedge clk_i);
    total++; if (req_ready_o !== 2'b10) begin bad++; $display("FAIL bp_ready1 got=%b exp=10", req_ready_o); end
    tick();
    @(negedge clk_i);
    total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL bp_full got=%b exp=00", req_ready_o); end
    total++; if (res_valid_o !== 1'b1 || res_o !== ea)
      begin bad++; $display("FAIL bp_head_a got=%b/%h exp=1/%h", res_valid_o, res_o, ea); end
    tick();
    res_ready_i = 1'b1;
    @(negedge clk_i);
    total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL bp_nocomb got=%b exp=00", req_ready_o); end
    total++; if (res_o !== ea) begin bad++; $display("FAIL bp_hold_a got=%h exp=%h", res_o, ea); end
    tick();
    @(negedge clk_i);
    total++; if (res_valid_o !== 1'b1 || res_o !== eb)
      begin bad++; $display("FAIL bp_head_b got=%b/%h exp=1/%h", res_valid_o, res_o, eb); end
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL bp_resume got=%b exp=01", req_ready_o); end
    tick();
    req_valid_i = 2'b00;
    @(negedge clk_i);
    total++; if (res_valid_o !== 1'b1 || res_o !== ec)
      begin bad++; $display("FAIL bp_head_c got=%b/%h exp=1/%h", res_valid_o, res_o, ec); end
    tick();
    @(negedge clk_i);
    total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", res_valid_o); end
  endtask

  task automatic test_branch();
    do_reset();
    req_valid_i = 2'b10;
    set_op(1, EQ, 32'd9, 32'd9, 3'd4);
    @(negedge clk_i);
    total++; if (req_ready_o !== 2'b10) begin bad++; $display("FAIL br_ready got=%b exp=10", req_ready_o); end
    tick();
    set_op(1, NE, 32'd9, 32'd9, 3'd6);
    @(negedge clk_i);
    total++; if (res_valid_o !== 1'b1 || res_o.branch_res !== 1'b1 || res_o.owner !== 1'b1 || res_o.trans_id !== 3'd4)
      begin bad++; $display("FAIL br_beq got=%b/%b/%b/%0d exp=1/1/1/4", res_valid_o, res_o.branch_res, res_o.owner, res_o.trans_id); end
    tick();
    req_valid_i = 2'b00;
    @(negedge clk_i);
    total++; if (res_valid_o !== 1'b1 || res_o.branch_res !== 1'b0 || res_o.owner !== 1'b1 || res_o.trans_id !== 3'd6)
      begin bad++; $display("FAIL br_bne got=%b/%b/%b/%0d exp=1/0/1/6", res_valid_o, res_o.branch_res, res_o.owner, res_o.trans_id); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    res_ready_i = 1'b0;
    set_op(0, ADD, 32'd1, 32'd1, 3'd1);
    set_op(1, ADD, 32'd2, 32'd2, 3'd2);
    req_valid_i = 2'b10;
    tick();
    req_valid_i = 2'b01;
    tick();
    req_valid_i = 2'b11;
    flush_i     = 1'b1;
    @(negedge clk_i);
    total++; if (req_ready_o !== 2'b00) begin bad++; $display("FAIL fl_ready got=%b exp=00", req_ready_o); end
    total++; if (res_valid_o !== 1'b1) begin bad++; $display("FAIL fl_full got=%b exp=1", res_valid_o); end
    tick();
    flush_i = 1'b0;
    @(negedge clk_i);
    total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL fl_empty got=%b exp=0", res_valid_o); end
    total++; if (req_ready_o !== 2'b10) begin bad++; $display("FAIL fl_ptr got=%b exp=10", req_ready_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    res_ready_i = 1'b0;
    req_valid_i = 2'b01;
    set_op(0, XORL, 32'hF0, 32'h0F, 3'd7);
    tick();
    req_valid_i = 2'b00;
    @(negedge clk_i);
    total++; if (res_valid_o !== 1'b1) begin bad++; $display("FAIL rm_before got=%b exp=1", res_valid_o); end
    rst_ni = 1'b0;
    #1;
    total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL rm_async got=%b exp=0", res_valid_o); end
    tick();
    rst_ni      = 1'b1;
    req_valid_i = 2'b11;
    @(negedge clk_i);
    total++; if (req_ready_o !== 2'b01) begin bad++; $display("FAIL rm_ptr got=%b exp=01", req_ready_o); end
    tick();
  endtask

  task automatic test_random();
    logic [1:0]     exp_ready;
    logic           exp_valid;
    int             w;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req_valid_i = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++)
        set_op(k, fu_op_t'(4'($urandom_range(0, 5))), xlen_t'($urandom_range(0, 15)),
               xlen_t'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      res_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 19) == 0);
      @(negedge clk_i);
      w         = req_valid_i[rr_m] ? rr_m : 1 - rr_m;
      exp_valid = (q_m.size() != 0);
      exp_ready = (req_valid_i != 2'b00 && q_m.size() < 2 && !flush_i) ? 2'(1 << w) : 2'b00;
      total++; if (req_ready_o !== exp_ready)
        begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", n, req_ready_o, exp_ready); end
      total++; if (res_valid_o !== exp_valid)
        begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, res_valid_o, exp_valid); end
      if (exp_valid) begin
        total++; if (res_o !== q_m[0])
          begin bad++; $display("FAIL rnd_res[%0d] got=%h exp=%h", n, res_o, q_m[0]); end
      end
      if (exp_valid && res_ready_i) void'(q_m.pop_front());
      if (flush_i) q_m.delete();
      if (exp_ready != 2'b00) begin
        q_m.push_back(mk_res(req_data_i[w], w));
        rr_m = (w + 1) % 2;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_branch();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
